alu: RTL and testbench
======================

# alu

Hack-style 16-bit arithmetic-logic unit with a registered result stage. Computes one of the Hack function set (add, AND, negations, constants, increments, decrements, subtractions) from two 16-bit operands under six control bits, and flags zero and negative results. Sits in the CPU datapath between the A/D/M operand sources and the register write-back path. Results appear one clock after the operands are sampled.

## Interface
Parameters: none. Width is fixed at 16 bits.

- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk
- in_valid  input  1  operands and controls valid this cycle
- x  input  16  operand X
- y  input  16  operand Y
- zx  input  1  zero X
- nx  input  1  bitwise-negate X, applied after zx
- zy  input  1  zero Y
- ny  input  1  bitwise-negate Y, applied after zy
- f  input  1  1 selects x+y; 0 selects x&y
- no  input  1  bitwise-negate the f result
- out  output  16  registered result, two's complement
- zr  output  1  registered; 1 when out == 0
- ng  output  1  registered; 1 when out[15] == 1
- out_valid  output  1  registered copy of in_valid

## Operation
- Combinational core, evaluated in this order:
  - x1 = zx ? 0 : x
  - x2 = nx ? ~x1 : x1
  - y1 = zy ? 0 : y
  - y2 = ny ? ~y1 : y1
  - r = f ? (x2 + y2) mod 2^16 : (x2 & y2)
  - o = no ? ~r : r
- zr_c = (o == 16'h0000); ng_c = o[15].
- Addition is 16-bit modulo; carry-out is discarded; no overflow flag.
- Core is a pure function of the current inputs. No internal state other than the output registers.
- Register load, each rising clk:
  - rst_n == 0: out = 0, zr = 1, ng = 0, out_valid = 0.
  - Otherwise, when in_valid == 1: out, zr and ng load o, zr_c and ng_c.
  - Otherwise (in_valid == 0): out, zr and ng hold their values.
  - out_valid loads in_valid.
- Flags are always consistent with out, including the reset state.
- Canonical codes (zx nx zy ny f no):
  - 101010 gives 0.
  - 111111 gives 1.
  - 111010 gives -1.
  - 001100 gives x.
  - 110000 gives y.
  - 000010 gives x+y.
  - 010011 gives x-y.
  - 000111 gives y-x.
  - 000000 gives x&y.
  - 010101 gives x|y.
- All 64 control combinations are legal and follow the equations above.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on out, zr, ng and out_valid after edge N.
- Throughput is one operation per cycle. No backpressure.
- Reset has priority over in_valid.
- If rst_n is asserted while a valid operation is in flight, that result is dropped and the reset values appear after the edge.
- The first valid result appears one cycle after rst_n deasserts and in_valid is high.
- Inputs may change every cycle. Only values present at the sampling edge matter.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with random inputs -> out=0, zr=1, ng=0, out_valid=0.
- Logic path: x=9, y=15, in_valid=1.
  - Controls 000000 -> next cycle out=9, zr=0, ng=0.
  - Controls 000010 -> out=24.
  - Controls 010101 -> out=15.
- Subtract and flags: x=9, y=15.
  - Controls 010011 -> out=16'hFFFA (-6), ng=1, zr=0.
  - Controls 000111 -> out=6.
  - Controls 101010 -> out=0, zr=1.
  - Controls 111111 -> out=1.
  - Controls 111010 -> out=16'hFFFF.
- Wrap: x=16'h7FFF, y=1, controls 000010 -> out=16'h8000, ng=1.
  - Then x=16'hFFFF, y=1 -> out=0, zr=1.
- Hold and valid: apply x=9, y=15, controls 000010 with in_valid=1, then change inputs with in_valid=0 for 3 cycles.
  - out stays 24 throughout.
  - out_valid shows 1 then 0.
  - Assert rst_n=0 mid-stream -> reset values appear the next cycle.
- Exhaustive sweep: x=9, y=15, step through all 64 control codes, one per cycle.
  - Each result must match the reference equations, delayed by one cycle.

Source files
------------

// File: rtl/alu_if.sv
// Operand/control bundle and registered result bus for the Hack-style ALU.
interface alu_if;
   logic        in_valid;
   logic [15:0] x;
   logic [15:0] y;
   logic        zx;
   logic        nx;
   logic        zy;
   logic        ny;
   logic        f;
   logic        no;
   logic [15:0] out;
   logic        zr;
   logic        ng;
   logic        out_valid;

   modport master (
      output in_valid, x, y, zx, nx, zy, ny, f, no,
      input  out, zr, ng, out_valid
   );

   modport slave (
      input  in_valid, x, y, zx, nx, zy, ny, f, no,
      output out, zr, ng, out_valid
   );
endinterface

// File: rtl/alu.sv
// Hack-style 16-bit ALU: combinational function core followed by one result register stage.
module alu (
   input logic clk,
   input logic rst_n,
   alu_if.slave bus
);
   logic [15:0] x1, x2, y1, y2, r, o;
   logic        zr_c, ng_c;

   always_comb begin
      x1   = bus.zx ? '0 : bus.x;
      x2   = bus.nx ? ~x1 : x1;
      y1   = bus.zy ? '0 : bus.y;
      y2   = bus.ny ? ~y1 : y1;
      r    = bus.f ? (x2 + y2) : (x2 & y2);
      o    = bus.no ? ~r : r;
      zr_c = (o == '0);
      ng_c = o[15];
   end

   // Result and flags hold when no valid operand arrives; reset value keeps zr consistent with out=0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.out       <= '0;
         bus.zr        <= 1'b1;
         bus.ng        <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.out <= o;
            bus.zr  <= zr_c;
            bus.ng  <= ng_c;
         end
      end
   end
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus queues expected register contents, a negedge monitor checks them.
module tb_alu;
   logic clk = 1'b0;
   logic rst_n;

   alu_if bus ();

   alu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] o;
      logic        z;
      logic        n;
      logic        v;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   int unsigned compared   = 0;
   int unsigned mismatched = 0;
   logic [15:0] held       = '0;

   function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                           input logic [5:0] c);
      logic [15:0] a1, b1, res;
      a1  = c[5] ? 16'h0000 : a;
      a1  = c[4] ? ~a1 : a1;
      b1  = c[3] ? 16'h0000 : b;
      b1  = c[2] ? ~b1 : b1;
      res = c[1] ? a1 + b1 : a1 & b1;
      return c[0] ? ~res : res;
   endfunction

   // Drive one cycle of inputs, then queue what the registers must hold after that edge.
   task automatic step(input logic r, input logic v, input logic [15:0] xx, input logic [15:0] yy,
                       input logic [5:0] c, input logic [15:0] eo, input string tag);
      exp_t e;
      rst_n        = r;
      bus.in_valid = v;
      bus.x        = xx;
      bus.y        = yy;
      {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = c;
      @(posedge clk);
      #1;
      if (!r)     held = 16'h0000;
      else if (v) held = eo;
      e.o   = held;
      e.z   = (held == 16'h0000);
      e.n   = held[15];
      e.v   = r & v;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input string tag, input logic [15:0] act,
                      input logic [15:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s.%s: got %h, expected %h", tag, name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("out",       e.tag, bus.out,              e.o);
         chk("zr",        e.tag, {15'd0, bus.zr},        {15'd0, e.z});
         chk("ng",        e.tag, {15'd0, bus.ng},        {15'd0, e.n});
         chk("out_valid", e.tag, {15'd0, bus.out_valid}, {15'd0, e.v});
      end
   end

   initial begin
      // Reset with random inputs
      for (int i = 0; i < 2; i++)
         step(1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 6'($urandom), 16'h0000, "reset");

      // Logic path and arithmetic with x=9, y=15
      step(1'b1, 1'b1, 16'd9, 16'd15, 6'b000000, 16'd9,    "and");
      step(1'b1, 1'b1, 16'd9, 16'd15, 6'b000010, 16'd24,   "add");
      step(1'b1, 1'b1, 16'd9, 16'd15, 6'b010101, 16'd15,   "or");
      step(1'b1, 1'b1, 16'd9, 16'd15, 6'b010011, 16'hFFFA, "x_minus_y");
      step(1'b1, 1'b1, 16'd9, 16'd15, 6'b000111, 16'd6,    "y_minus_x");
      step(1'b1, 1'b1, 16'd9, 16'd15, 6'b101010, 16'd0,    "zero");
      step(1'b1, 1'b1, 16'd9, 16'd15, 6'b111111, 16'd1,    "one");
      step(1'b1, 1'b1, 16'd9, 16'd15, 6'b111010, 16'hFFFF, "minus_one");
      step(1'b1, 1'b1, 16'd9, 16'd15, 6'b001100, 16'd9,    "pass_x");
      step(1'b1, 1'b1, 16'd9, 16'd15, 6'b110000, 16'd15,   "pass_y");

      // Modulo wrap
      step(1'b1, 1'b1, 16'h7FFF, 16'h0001, 6'b000010, 16'h8000, "wrap_pos");
      step(1'b1, 1'b1, 16'hFFFF, 16'h0001, 6'b000010, 16'h0000, "wrap_zero");

      // Hold while in_valid is low, then reset mid-stream drops an in-flight op
      step(1'b1, 1'b1, 16'd9, 16'd15, 6'b000010, 16'd24, "hold_load");
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 16'($urandom), 16'($urandom), 6'($urandom), 16'h0000, "hold");
      step(1'b0, 1'b1, 16'h7FFF, 16'h0001, 6'b000010, 16'h0000, "reset_mid");
      step(1'b1, 1'b1, 16'h7FFF, 16'h0001, 6'b000010, 16'h8000, "after_reset");

      // All 64 control codes against the reference equations
      for (int c = 0; c < 64; c++)
         step(1'b1, 1'b1, 16'd9, 16'd15, 6'(c), ref_alu(16'd9, 16'd15, 6'(c)), $sformatf("sweep%0d", c));
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 6'b000000, 16'h0000, "idle");

      @(negedge clk);
      #1;
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
